// File: rtl/riscv_bus_pkg.sv
// Shared bus types and default address map for the core's data-memory request path.
package riscv_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } bus_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } bus_req_t;

   localparam logic [31:0] DEF_MMIO_BASE = 32'h4000_0000;
   localparam logic [31:0] DEF_MMIO_SIZE = 32'h0001_0000;
   localparam logic [31:0] DEF_ERR_DATA  = 32'hDEAD_BEEF;

endpackage

// File: rtl/addr_window_dec.sv
// Combinational [BASE, BASE+SIZE) window hit; 33-bit compare so the window end never wraps.
module addr_window_dec #(
   parameter logic [31:0] BASE = 32'h4000_0000,
   parameter logic [31:0] SIZE = 32'h0001_0000
) (
   input  logic [31:0] addr_i,
   output logic        hit_o
);

   logic [32:0] addr_ext;
   logic [32:0] lo;
   logic [32:0] hi;

   assign addr_ext = {1'b0, addr_i};
   assign lo       = {1'b0, BASE};
   assign hi       = {1'b0, BASE} + {1'b0, SIZE};
   assign hit_o    = (addr_ext >= lo) && (addr_ext < hi);

endmodule

// File: rtl/mem_bus_demux.sv
// 1-to-2 load/store router: data RAM on port 0, MMIO window on port 1, one
// outstanding transaction with a timeout that answers with an error response.
module mem_bus_demux
   import riscv_bus_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
   parameter logic [31:0] MMIO_SIZE = DEF_MMIO_SIZE,
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        p0_valid,
   input  logic        p0_ready,
   output logic [31:0] p0_addr,
   output logic        p0_we,
   output logic [31:0] p0_wdata,
   output logic [3:0]  p0_wstrb,
   input  logic        p0_rsp_valid,
   input  logic [31:0] p0_rsp_rdata,
   output logic        p1_valid,
   input  logic        p1_ready,
   output logic [31:0] p1_addr,
   output logic        p1_we,
   output logic [31:0] p1_wdata,
   output logic [3:0]  p1_wstrb,
   input  logic        p1_rsp_valid,
   input  logic [31:0] p1_rsp_rdata,
   output bus_state_t  dbg_state_o
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   bus_state_t  state_q, state_d;
   bus_req_t    req_q, req_d;
   logic        sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;

   logic        sel_hit;
   logic        tgt_ready;
   logic        tgt_rsp_valid;
   logic [31:0] tgt_rsp_rdata;
   logic        expired;

   addr_window_dec #(
      .BASE(MMIO_BASE),
      .SIZE(MMIO_SIZE)
   ) u_dec (
      .addr_i(req_addr),
      .hit_o (sel_hit)
   );

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready and the request stays stable until then.
   assign tgt_ready     = sel_q ? p1_ready     : p0_ready;
   assign tgt_rsp_valid = sel_q ? p1_rsp_valid : p0_rsp_valid;
   assign tgt_rsp_rdata = sel_q ? p1_rsp_rdata : p0_rsp_rdata;
   assign expired       = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               req_d   = '{addr: req_addr, we: req_we, wdata: req_wdata, wstrb: req_wstrb};
               sel_d   = sel_hit;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d = cnt_q + CW'(1);
            if (expired) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = ERR_DATA;
               state_d     = IDLE;
            end else if (tgt_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // A response arriving on the expiry cycle still completes normally.
            if (tgt_rsp_valid) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = tgt_rsp_rdata;
               state_d     = IDLE;
            end else if (expired) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = ERR_DATA;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         req_q       <= '0;
         sel_q       <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign p0_valid    = (state_q == ISSUE) && !sel_q;
   assign p1_valid    = (state_q == ISSUE) && sel_q;
   assign p0_addr     = req_q.addr;
   assign p0_we       = req_q.we;
   assign p0_wdata    = req_q.wdata;
   assign p0_wstrb    = req_q.wstrb;
   assign p1_addr     = req_q.addr;
   assign p1_we       = req_q.we;
   assign p1_wdata    = req_q.wdata;
   assign p1_wstrb    = req_q.wstrb;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_demux.sv
// Self-checking bench for mem_bus_demux: directed vector table, reset-abort
// sequence, and randomized transactions against a cycle-count reference model.
module tb_mem_bus_demux;
   import riscv_bus_pkg::*;

   localparam int TIMEOUT = 16;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic        clk, reset;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        p0_valid, p0_ready, p0_we, p0_rsp_valid;
   logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
   logic [3:0]  p0_wstrb;
   logic        p1_valid, p1_ready, p1_we, p1_rsp_valid;
   logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
   logic [3:0]  p1_wstrb;
   bus_state_t  dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   mem_bus_demux #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_we(p0_we),
      .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb), .p0_rsp_valid(p0_rsp_valid),
      .p0_rsp_rdata(p0_rsp_rdata),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_we(p1_we),
      .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb), .p1_rsp_valid(p1_rsp_valid),
      .p1_rsp_rdata(p1_rsp_rdata),
      .dbg_state_o(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          d_ready;
      int          d_rsp;
      logic [31:0] rdata;
      logic        exp_sel;
      logic        exp_err;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // reference model: routing from the address map, outcome from cycle counts
   function automatic logic model_sel(input logic [31:0] a);
      longint unsigned x = 64'(a);
      return (x >= 64'h4000_0000) && (x < 64'h4000_0000 + 64'h1_0000);
   endfunction

   function automatic logic model_err(input int d_ready, input int d_rsp);
      return !((d_ready <= TIMEOUT - 2) && (d_ready + d_rsp + 2 <= TIMEOUT));
   endfunction

   task automatic idle_inputs();
      req_valid = 0; req_addr = '0; req_we = 0; req_wdata = '0; req_wstrb = '0;
      p0_ready = 0; p1_ready = 0; p0_rsp_valid = 0; p1_rsp_valid = 0;
      p0_rsp_rdata = '0; p1_rsp_rdata = '0;
   endtask

   // driver: one full transaction; cycle c = 0 is the first ISSUE cycle
   task automatic run_txn(input vec_t v);
      int issue_last, exp_c, real_c;
      logic [31:0] exp_rd;
      logic sv, ov, srsp, orsp;
      issue_last = (v.d_ready < TIMEOUT - 1) ? v.d_ready : TIMEOUT - 1;
      exp_c      = v.exp_err ? TIMEOUT : v.d_ready + v.d_rsp + 2;
      exp_rd     = v.exp_err ? ERRD : v.rdata;
      real_c     = v.d_ready + 1 + v.d_rsp;
      @(negedge clk);
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      req_valid = 1; req_addr = v.addr; req_we = v.we; req_wdata = v.wdata; req_wstrb = v.wstrb;
      @(negedge clk);
      req_valid = 0; req_addr = $urandom; req_we = ~v.we; req_wdata = $urandom; req_wstrb = 4'($urandom);
      for (int c = 0; c <= exp_c + 2; c++) begin
         sv = v.exp_sel ? p1_valid : p0_valid;
         ov = v.exp_sel ? p0_valid : p1_valid;
         chk("sel_port_valid", 32'(sv), 32'(c <= issue_last));
         chk("other_port_valid", 32'(ov), 32'd0);
         chk("rsp_valid", 32'(rsp_valid), 32'(c == exp_c));
         chk("req_ready", 32'(req_ready), 32'(c >= exp_c));
         if (c == 0) begin
            chk("fld_addr", v.exp_sel ? p1_addr : p0_addr, v.addr);
            chk("fld_we", 32'(v.exp_sel ? p1_we : p0_we), 32'(v.we));
            chk("fld_wdata", v.exp_sel ? p1_wdata : p0_wdata, v.wdata);
            chk("fld_wstrb", 32'(v.exp_sel ? p1_wstrb : p0_wstrb), 32'(v.wstrb));
         end
         if (c == exp_c) chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
         if (c >= exp_c) chk("rsp_rdata", rsp_rdata, exp_rd);
         // drive the rest of cycle c: real response plus ignored noise pulses
         srsp = (c == real_c) || (c == 0 && v.d_ready >= 1) || (c == exp_c + 1);
         orsp = (c == issue_last + 1) || (c == exp_c + 1);
         if (v.exp_sel) begin
            p1_ready = (c >= v.d_ready); p0_ready = 1;
            p1_rsp_valid = srsp; p0_rsp_valid = orsp;
            p1_rsp_rdata = (c == real_c) ? v.rdata : 32'hBAD0_0000 | 32'(c);
            p0_rsp_rdata = 32'hBAD1_0000 | 32'(c);
         end else begin
            p0_ready = (c >= v.d_ready); p1_ready = 1;
            p0_rsp_valid = srsp; p1_rsp_valid = orsp;
            p0_rsp_rdata = (c == real_c) ? v.rdata : 32'hBAD0_0000 | 32'(c);
            p1_rsp_rdata = 32'hBAD1_0000 | 32'(c);
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_p0_valid"}, 32'(p0_valid), 32'd0);
      chk({tag, "_p1_valid"}, 32'(p1_valid), 32'd0);
      chk({tag, "_p0_addr"}, p0_addr, 32'd0);
      chk({tag, "_p1_wdata"}, p1_wdata, 32'd0);
      chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
   endtask

   initial begin
      vec_t v;
      int a_sel;
      logic [31:0] a;
      //           addr          we wdata          wstrb  drdy drsp rdata          sel err
      vecs[0]  = '{32'h0000_0010, 0, 32'h0,         4'hF,  0,   0, 32'h1234_5678, 0, 0};
      vecs[1]  = '{32'h4000_0004, 1, 32'h0000_00A5, 4'h1,  0,   0, 32'h0000_0000, 1, 0};
      vecs[2]  = '{32'h3FFF_FFFC, 0, 32'h0,         4'hF,  1,   2, 32'hAAAA_0001, 0, 0};
      vecs[3]  = '{32'h4000_FFFC, 0, 32'h0,         4'hF,  2,   1, 32'hAAAA_0002, 1, 0};
      vecs[4]  = '{32'h4001_0000, 1, 32'h1111_2222, 4'hC,  0,   3, 32'hAAAA_0003, 0, 0};
      vecs[5]  = '{32'hFFFF_FFFC, 0, 32'h0,         4'hF,  0,   0, 32'hAAAA_0004, 0, 0};
      vecs[6]  = '{32'h4000_0000, 1, 32'h3333_4444, 4'h3,  1,   0, 32'hAAAA_0005, 1, 0};
      vecs[7]  = '{32'h4000_0008, 0, 32'h0,         4'hF, 20,   0, 32'hAAAA_0006, 1, 1};
      vecs[8]  = '{32'h0000_0100, 0, 32'h0,         4'hF,  3,  11, 32'hAAAA_0007, 0, 0};
      vecs[9]  = '{32'h0000_0104, 0, 32'h0,         4'hF,  3,  12, 32'hAAAA_0008, 0, 1};
      vecs[10] = '{32'h4000_1000, 0, 32'h0,         4'hF, 14,   0, 32'hAAAA_0009, 1, 0};
      vecs[11] = '{32'h4000_1004, 0, 32'h0,         4'hF, 15,   0, 32'hAAAA_000A, 1, 1};

      idle_inputs();
      reset = 1'b1;
      #3;
      chk_reset_values("por");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) run_txn(vecs[i]);

      // reset while waiting for a response aborts silently
      @(negedge clk);
      req_valid = 1; req_addr = 32'h0000_0020; req_we = 0; req_wstrb = 4'hF;
      @(negedge clk);
      req_valid = 0; p0_ready = 1;
      @(negedge clk);
      p0_ready = 0;
      chk("abort_in_wait", 32'(dbg_state), 32'(WAIT));
      #2 reset = 1'b1;
      #1 chk_reset_values("abort");
      @(negedge clk);
      reset = 1'b0;
      p0_rsp_valid = 1; p0_rsp_rdata = 32'h5555_6666;
      @(negedge clk);
      p0_rsp_valid = 0;
      for (int k = 0; k < 3; k++) begin
         chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
         chk("abort_rdata", rsp_rdata, 32'd0);
         @(negedge clk);
      end
      run_txn(vecs[0]);

      // randomized transactions against the model
      for (int i = 0; i < 40; i++) begin
         a_sel = $urandom_range(0, 3);
         case (a_sel)
            0: a = 32'h4000_0000 + 32'($urandom_range(0, 32'hFFFF));
            1: a = 32'h3FFF_FFF0 + 32'($urandom_range(0, 31));
            2: a = 32'h4000_FFF0 + 32'($urandom_range(0, 31));
            default: a = $urandom;
         endcase
         v.addr    = a;
         v.we      = 1'($urandom);
         v.wdata   = $urandom;
         v.wstrb   = 4'($urandom);
         v.d_ready = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 3);
         v.d_rsp   = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 14) : $urandom_range(0, 3);
         v.rdata   = $urandom;
         v.exp_sel = model_sel(a);
         v.exp_err = model_err(v.d_ready, v.d_rsp);
         run_txn(v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
